// File: rtl/game_flow_pkg.sv
// Shared types for the game flow block: FSM state encoding, 3-bit RGB
// constants and the layer-priority function used by the pixel compositor.
package game_flow_pkg;

  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    DYING     = 3'd1,
    LEVEL_WON = 3'd2,
    GAME_OVER = 3'd3,
    VICTORY   = 3'd4
  } state_t;

  // RGB3 packing: bit 2 = red, bit 1 = green, bit 0 = blue.
  localparam logic [2:0] RGB_BLACK  = 3'b000;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_CYAN   = 3'b011;
  localparam logic [2:0] RGB_WHITE  = 3'b111;

  // Playfield layer priority; frog_rgb lets the dying frog render red.
  function automatic logic [2:0] play_rgb(
    input logic [2:0] frog_rgb,
    input logic       frog_px,
    input logic [2:0] car_rgb,
    input logic       border_px,
    input logic       text_px,
    input logic       yellow_px,
    input logic       white_px,
    input logic       end_zone_px
  );
    logic [2:0] rgb;
    if (frog_px) begin
      rgb = frog_rgb;
    end else if (car_rgb != 3'd0) begin
      rgb = car_rgb;
    end else if (border_px && !text_px) begin
      rgb = RGB_WHITE;
    end else if (yellow_px) begin
      rgb = RGB_YELLOW;
    end else if (white_px) begin
      rgb = RGB_WHITE;
    end else if (end_zone_px) begin
      rgb = RGB_CYAN;
    end else begin
      rgb = RGB_BLACK;
    end
    return rgb;
  endfunction

endpackage

// File: rtl/game_flow_compositor_pixel_compositor.sv
// pixel_compositor: two-stage pixel pipeline. Stage 1 registers a 3-bit
// colour decision from the layer bits and the FSM state; stage 2 expands
// each bit to a full COLOR_W channel on the VGA pins.
module pixel_compositor
  import game_flow_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic               flash,
  input  logic               screen_area,
  input  logic               frog_px,
  input  logic               border_px,
  input  logic               text_px,
  input  logic               yellow_px,
  input  logic               white_px,
  input  logic               end_zone_px,
  input  logic [2:0]         car_rgb,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  logic [2:0] play_s;
  logic [2:0] dying_s;
  logic [2:0] rgb_s;
  logic [2:0] rgb_r;

  // Colour decision for the current pixel, before any registering.
  always_comb begin
    play_s  = play_rgb(RGB_GREEN, frog_px, car_rgb, border_px, text_px,
                       yellow_px, white_px, end_zone_px);
    dying_s = play_rgb(RGB_RED, frog_px, car_rgb, border_px, text_px,
                       yellow_px, white_px, end_zone_px);
    rgb_s   = RGB_BLACK;
    if (!screen_area) begin
      rgb_s = RGB_BLACK;
    end else begin
      case (state_t'(state))
        PLAY:      rgb_s = play_s;
        DYING: begin
          if (flash) begin
            rgb_s = RGB_RED;
          end else begin
            rgb_s = dying_s;
          end
        end
        LEVEL_WON,
        VICTORY:   rgb_s = text_px ? RGB_BLACK : RGB_GREEN;
        GAME_OVER: rgb_s = text_px ? RGB_BLACK : RGB_RED;
        default:   rgb_s = RGB_BLACK;
      endcase
    end
  end

  // Stage 1: register the 3-bit colour decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_r <= RGB_BLACK;
    end else begin
      rgb_r <= rgb_s;
    end
  end

  // Stage 2: replicate each colour bit across its channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= {COLOR_W{rgb_r[2]}};
      vga_g <= {COLOR_W{rgb_r[1]}};
      vga_b <= {COLOR_W{rgb_r[0]}};
    end
  end

endmodule

// File: rtl/game_flow_compositor.sv
// game_flow_compositor: game flow FSM (levels, lives, respawn delay,
// level-won / game-over / victory screens) plus the registered pixel
// compositor feeding the VGA pins.
// Optional build macro GAME_FLOW_DEATH_FLASH_EN: while DYING, the whole
// visible area alternates red and normal rendering on frame counter bit 3.
module game_flow_compositor
  import game_flow_pkg::*;
#(
  parameter  int NUM_LEVELS     = 4,
  parameter  int LIVES          = 3,
  parameter  int RESPAWN_FRAMES = 60,
  parameter  int HOLD_FRAMES    = 90,
  parameter  int COLOR_W        = 8,
  localparam int LVL_W          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               screen_area,
  input  logic               hit,
  input  logic               reached_end,
  input  logic               frog_px,
  input  logic               border_px,
  input  logic               text_px,
  input  logic               yellow_px,
  input  logic               white_px,
  input  logic               end_zone_px,
  input  logic [2:0]         car_rgb,
  output logic [LVL_W-1:0]   level,
  output logic [2:0]         lives_left,
  output logic [2:0]         state,
  output logic               frog_respawn,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > HOLD_FRAMES) ? RESPAWN_FRAMES : HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

  state_t           state_r;
  logic [LVL_W-1:0] level_r;
  logic [2:0]       lives_r;
  logic [CNT_W-1:0] cnt_r;
  logic             frog_respawn_r;
  logic             flash_s;

  // Game flow FSM with its level, lives and frame counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= PLAY;
      level_r        <= '0;
      lives_r        <= LIVES_INIT;
      cnt_r          <= '0;
      frog_respawn_r <= 1'b0;
    end else begin
      frog_respawn_r <= 1'b0;
      case (state_r)
        PLAY: begin
          if (hit) begin
            // Losing the last life skips the respawn delay entirely.
            lives_r <= lives_r - 3'd1;
            cnt_r   <= '0;
            state_r <= (lives_r == 3'd1) ? GAME_OVER : DYING;
          end else if (reached_end) begin
            cnt_r   <= '0;
            state_r <= LEVEL_WON;
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (cnt_r == RESP_LAST) begin
              cnt_r          <= '0;
              state_r        <= PLAY;
              frog_respawn_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        LEVEL_WON: begin
          if (frame_tick) begin
            if (cnt_r == HOLD_LAST) begin
              cnt_r <= '0;
              if (level_r == LAST_LEVEL) begin
                state_r <= VICTORY;
              end else begin
                level_r        <= level_r + LVL_ONE;
                state_r        <= PLAY;
                frog_respawn_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        GAME_OVER,
        VICTORY: begin
          if (start) begin
            level_r        <= '0;
            lives_r        <= LIVES_INIT;
            cnt_r          <= '0;
            state_r        <= PLAY;
            frog_respawn_r <= 1'b1;
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= PLAY;
        end
      endcase
    end
  end

`ifdef GAME_FLOW_DEATH_FLASH_EN
  localparam int FLASH_BIT = (CNT_W > 3) ? 3 : CNT_W - 1;
  // Flash phase follows frame counter bit 3 (toggles every 8th tick).
  always_comb begin
    if (CNT_W > 3) begin
      flash_s = cnt_r[FLASH_BIT];
    end else begin
      flash_s = 1'b0;
    end
  end
`else
  // No death flash: only the frog pixel changes colour while dying.
  always_comb begin
    flash_s = 1'b0;
  end
`endif

  pixel_compositor #(
    .COLOR_W (COLOR_W)
  ) u_pixel_compositor (
    .clk         (clk),
    .rst         (rst),
    .state       (state_r),
    .flash       (flash_s),
    .screen_area (screen_area),
    .frog_px     (frog_px),
    .border_px   (border_px),
    .text_px     (text_px),
    .yellow_px   (yellow_px),
    .white_px    (white_px),
    .end_zone_px (end_zone_px),
    .car_rgb     (car_rgb),
    .vga_r       (VGA_R),
    .vga_g       (VGA_G),
    .vga_b       (VGA_B)
  );

  assign level        = level_r;
  assign lives_left   = lives_r;
  assign state        = state_r;
  assign frog_respawn = frog_respawn_r;

endmodule

// File: doc/game_flow_compositor.md
Name: game_flow_compositor

Overview:
Parametrised successor to the single-level game top: owns game flow (N levels, lives, respawn delay, level-won and game-over screens) and the registered pixel compositor that turns per-pixel layer bits into VGA colour.
- Sits between the sprite/obstacle/collision generators and the VGA pins.
- Drives level select and frog respawn back to those generators.
- Level advance is automatic; no level switch.

Parameters:
- NUM_LEVELS, 4, number of levels; legal range 1..16.
- LIVES, 3, lives at game start; legal range 1..7.
- RESPAWN_FRAMES, 60, frame_tick count spent in DYING.
- HOLD_FRAMES, 90, frame_tick count spent in LEVEL_WON.
- COLOR_W, 8, bits per VGA colour channel.

Ports:
- clk  in  1  VGA pixel clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame.
- start  in  1  level-sensitive restart request.
- screen_area  in  1  pixel is in the visible area.
- hit  in  1  collision this cycle.
- reached_end  in  1  frog is in the end zone.
- frog_px  in  1  pixel layer bit.
- border_px  in  1  pixel layer bit.
- text_px  in  1  pixel layer bit.
- yellow_px  in  1  pixel layer bit.
- white_px  in  1  pixel layer bit.
- end_zone_px  in  1  pixel layer bit.
- car_rgb  in  3  resolved obstacle colour; 0 means no car.
- level  out  LVL_W=$clog2(NUM_LEVELS) (min 1)  current level index.
- lives_left  out  3  remaining lives.
- state  out  3  FSM state encoding.
- frog_respawn  out  1  one-cycle pulse that returns the frog to start.
- VGA_R  out  COLOR_W  red channel.
- VGA_G  out  COLOR_W  green channel.
- VGA_B  out  COLOR_W  blue channel.

Behaviour:
- Reset (rst=0, async) values:
  - state=PLAY, level=0, lives_left=LIVES, frog_respawn=0, frame counter=0.
  - VGA_R/G/B=0 and both pipeline stages cleared.
  - Reset mid-frame takes effect immediately; no partial state survives.
- FSM states:
  - PLAY (0):
    - hit → DYING.
    - else reached_end → LEVEL_WON.
    - hit and reached_end in the same cycle → DYING (hit has priority).
  - DYING (1):
    - Entry decrements lives_left and clears the frame counter.
    - If the decremented value is 0, go straight to GAME_OVER instead.
    - Counter increments on frame_tick; at RESPAWN_FRAMES-1 with frame_tick → PLAY, pulsing frog_respawn.
    - hit and reached_end are ignored in this state.
  - LEVEL_WON (2):
    - Counter runs to HOLD_FRAMES-1 as in DYING.
    - Then, if level==NUM_LEVELS-1 → VICTORY; otherwise level+1 and PLAY with frog_respawn pulse.
    - lives_left is unchanged.
  - GAME_OVER (3), VICTORY (4):
    - Hold until start=1.
    - Then level=0, lives_left=LIVES, frog_respawn pulse, → PLAY.
  - start is ignored in all other states.
- frog_respawn is asserted exactly the cycle the FSM re-enters PLAY.
- Frame counter width is $clog2(max(RESPAWN_FRAMES, HOLD_FRAMES)+1).
  - The counter never wraps; it is cleared on every state entry.
- Compositor: 2-cycle latency from layer inputs to VGA pins.
  - Stage 1 registers a 3-bit RGB decision.
  - Stage 2 replicates each bit to COLOR_W.
  - FSM state is sampled at stage 1.
- PLAY priority:
  1. frog_px → green (0,1,0).
  2. car_rgb≠0 → car_rgb.
  3. border_px & !text_px → white.
  4. yellow_px → yellow (1,1,0).
  5. white_px → white.
  6. end_zone_px → cyan (0,1,1).
  7. Otherwise black.
- DYING: same as PLAY, except the frog pixel shows red.
- LEVEL_WON and VICTORY: green where screen_area & !text_px; else black.
- GAME_OVER: red where screen_area & !text_px; else black.
- screen_area=0 forces black in every state.

Optional Feature:
- Macro: GAME_FLOW_DEATH_FLASH_EN.
- Defined: in DYING, the whole screen_area alternates red and normal PLAY rendering.
  - Toggles on every 8th frame_tick, using frame counter bit 3.
  - The frog pixel stays red throughout.
- Undefined: no flashing; only the frog pixel turns red.

Decomposition:
- Package game_flow_pkg holds:
  - state enum: PLAY=0, DYING=1, LEVEL_WON=2, GAME_OVER=3, VICTORY=4.
  - RGB3 constants: BLACK, RED, GREEN, YELLOW, CYAN, WHITE.
- One sub-module, pixel_compositor: the 2-stage pipeline.
  - Inputs: layer bits, state, flash phase.
- The FSM and counters stay in the top block.

Test Plan:
- Reset release, hit pulse at frame 0 → state=DYING and lives_left=2 next cycle; after 60 frame_ticks, frog_respawn pulses once and state=PLAY.
- hit and reached_end asserted in the same cycle → DYING; level unchanged; lives_left decrements by 1.
- reached_end at level 3 (NUM_LEVELS=4) → LEVEL_WON; after 90 ticks → VICTORY (state=4); start=1 → level=0, lives_left=3, PLAY.
- Three hits with respawns between them → third hit gives GAME_OVER; lives_left=0; hit and start=0 are ignored; start=1 restores PLAY.
- PLAY with frog_px=1 and car_rgb=5 on the same pixel → VGA_G=8'hFF, VGA_R=VGA_B=0 exactly 2 cycles later; screen_area=0 gives all zero.
- rst asserted mid-LEVEL_WON → outputs zero without waiting for a clk edge; after release, level=0 and PLAY.
